lfsr_capture_display: RTL and testbench
=======================================

Name: lfsr_capture_display

Overview:
Downstream consumer of the 8-bit LFSR pseudo-random generator on the board.
- Continuously receives the generator's current 8-bit state on din.
- On a debounced push-button press, freezes the current value into a holding register.
- Shows the held byte as two hex digits on active-low seven-segment displays.
- Counts captures and emits a one-cycle capture strobe for other logic.

Parameters:
DEB_CYCLES, 4, consecutive synchronized samples required to accept a button level change; legal range 1..2^DEB_W-1 (board build uses 1000000).
DEB_W, 20, width of the debounce counter.

Ports:
clk  input  1  system clock; all state updates on rising edge.
rst  input  1  reset, asynchronous, active-high; clears all state immediately.
din  input  8  current LFSR state; sampled only at capture.
btn  input  1  raw push-button, asynchronous to clk, active-high.
held  output  8  last captured value.
valid  output  1  high once at least one capture has occurred since reset.
cap_pulse  output  1  high for exactly one cycle, the cycle after held updates.
cap_count  output  4  number of captures since reset, modulo 16.
hex0  output  7  low-nibble segments, active-low; bit0=a … bit6=g.
hex1  output  7  high-nibble segments, same encoding.

Behaviour:
Reset (asynchronous assert, synchronous release):
- held=0, valid=0, cap_pulse=0, cap_count=0, hex0=hex1=7'h7F (blank).
- Synchronizer flops = 0, debounce counter = 0, FSM = IDLE.

Synchronizer:
- Two flops, btn -> s1 -> btn_s.
- Only btn_s is used; btn reaches btn_s after 2 edges.

FSM states IDLE, DEB_PRESS, HELD, DEB_REL; the counter clears on every state change.
- IDLE: btn_s=1 -> DEB_PRESS with cnt=1; otherwise stay.
- DEB_PRESS:
  - btn_s=0 -> IDLE (glitch rejected, no capture).
  - btn_s=1 and cnt=DEB_CYCLES-1 -> HELD and capture.
  - Otherwise cnt+1.
  - With DEB_CYCLES=1, IDLE goes directly to HELD and captures on the first btn_s=1 sample.
- HELD: btn_s=0 -> DEB_REL with cnt=1; otherwise stay. Holding the button produces no further captures.
- DEB_REL:
  - btn_s=1 -> HELD (release glitch).
  - btn_s=0 and cnt=DEB_CYCLES-1 -> IDLE.
  - Otherwise cnt+1.

Capture (on the clock edge of the DEB_PRESS->HELD transition):
- held <= din at that edge; valid <= 1; cap_count <= cap_count+1 (15 wraps to 0).
- cap_pulse=1 for the following cycle only.

Latency:
- btn held high continuously -> capture at the (DEB_CYCLES+2)-th rising edge counting from the first edge sampling btn=1.
- din sampled at that same edge.

Display (registered, updated on the same edge as held):
- While valid=0: both digits blank (7'h7F).
- Afterwards: hex0=seg(held[3:0]), hex1=seg(held[7:4]).

seg() encoding, hex values:
- 0:40 1:79 2:24 3:30 4:19 5:12 6:02 7:78
- 8:00 9:10 A:08 b:03 C:46 d:21 E:06 F:0E

Boundary conditions:
- din changes every cycle (free-running LFSR): the value captured is the one present at the capture edge, with no averaging.
- rst asserted mid-debounce or mid-capture: immediate return to reset values and no partial capture.
- btn high while rst deasserts: treated as a fresh press and captured after full latency.
- rst has priority over capture in the same cycle.

Test Plan:
- Reset, btn=0 for 20 cycles -> hex0=hex1=7F, valid=0, cap_count=0, cap_pulse never high.
- DEB_CYCLES=4, din=8'hA5, btn high 10 cycles -> one capture at edge 6: held=A5, hex1=08, hex0=12, valid=1, cap_count=1, single cap_pulse.
- btn high for 3 cycles then low (glitch shorter than 2+DEB_CYCLES) -> no capture; held, cap_count unchanged.
- Held press with 1-cycle low glitch, then release 10 cycles, then new press with din=8'h3C -> exactly two captures total; final hex1=30, hex0=46.
- 17 full press/release cycles -> cap_count wraps to 1; cap_pulse count = 17.
- rst asserted asynchronously (between clock edges) during DEB_PRESS after a prior capture of 8'hFF -> outputs return to reset values immediately, before the next clk edge; no capture.

Source files
------------

// File: rtl/lfsr_capture_display.sv
// rtl/lfsr_capture_display.sv - captures the LFSR byte on a debounced button press and shows it as two hex digits
module lfsr_capture_display #(
  parameter int DEB_CYCLES = 4,
  parameter int DEB_W      = 20
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] din,
  input  logic       btn,
  output logic [7:0] held,
  output logic       valid,
  output logic       cap_pulse,
  output logic [3:0] cap_count,
  output logic [6:0] hex0,
  output logic [6:0] hex1
);

  typedef enum logic [1:0] {IDLE, DEB_PRESS, HELD, DEB_REL} state_t;

  localparam logic [DEB_W-1:0] CNT_LAST = DEB_W'(DEB_CYCLES - 1);
  localparam logic [DEB_W-1:0] CNT_ONE  = DEB_W'(1);
  localparam logic [6:0]       BLANK    = 7'h7F;

  function automatic logic [6:0] seg(input logic [3:0] n);
    case (n)
      4'h0: seg = 7'h40;  4'h1: seg = 7'h79;  4'h2: seg = 7'h24;  4'h3: seg = 7'h30;
      4'h4: seg = 7'h19;  4'h5: seg = 7'h12;  4'h6: seg = 7'h02;  4'h7: seg = 7'h78;
      4'h8: seg = 7'h00;  4'h9: seg = 7'h10;  4'hA: seg = 7'h08;  4'hB: seg = 7'h03;
      4'hC: seg = 7'h46;  4'hD: seg = 7'h21;  4'hE: seg = 7'h06;  default: seg = 7'h0E;
    endcase
  endfunction

  logic             s1_q, btn_s_q;
  state_t           state_q, state_d;
  logic [DEB_W-1:0] cnt_q, cnt_d;
  logic [7:0]       held_q, held_d;
  logic             valid_q, valid_d;
  logic             cap_pulse_q, cap_pulse_d;
  logic [3:0]       cap_count_q, cap_count_d;
  logic [6:0]       hex0_q, hex0_d, hex1_q, hex1_d;
  logic             capture;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_q        <= 1'b0;
      btn_s_q     <= 1'b0;
      state_q     <= IDLE;
      cnt_q       <= '0;
      held_q      <= 8'h00;
      valid_q     <= 1'b0;
      cap_pulse_q <= 1'b0;
      cap_count_q <= 4'h0;
      hex0_q      <= BLANK;
      hex1_q      <= BLANK;
    end else begin
      s1_q        <= btn;
      btn_s_q     <= s1_q;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      held_q      <= held_d;
      valid_q     <= valid_d;
      cap_pulse_q <= cap_pulse_d;
      cap_count_q <= cap_count_d;
      hex0_q      <= hex0_d;
      hex1_q      <= hex1_d;
    end
  end

  // Counter restarts on every state change; entering a debounce state counts the first sample.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (btn_s_q) begin
          state_d = (DEB_CYCLES == 1) ? HELD : DEB_PRESS;
          cnt_d   = (DEB_CYCLES == 1) ? '0 : CNT_ONE;
        end
      end
      DEB_PRESS: begin
        if (!btn_s_q) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = HELD;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      HELD: begin
        if (!btn_s_q) begin
          state_d = (DEB_CYCLES == 1) ? IDLE : DEB_REL;
          cnt_d   = (DEB_CYCLES == 1) ? '0 : CNT_ONE;
        end
      end
      DEB_REL: begin
        if (btn_s_q) begin
          state_d = HELD;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_comb begin
    capture = 1'b0;
    if (state_q == IDLE && btn_s_q && DEB_CYCLES == 1)
      capture = 1'b1;
    if (state_q == DEB_PRESS && btn_s_q && cnt_q == CNT_LAST)
      capture = 1'b1;
  end

  // Display digits are registered alongside held so they never show a half-updated byte.
  always_comb begin
    held_d      = held_q;
    valid_d     = valid_q;
    cap_count_d = cap_count_q;
    hex0_d      = hex0_q;
    hex1_d      = hex1_q;
    cap_pulse_d = capture;
    if (capture) begin
      held_d      = din;
      valid_d     = 1'b1;
      cap_count_d = cap_count_q + 4'd1;
      hex0_d      = seg(din[3:0]);
      hex1_d      = seg(din[7:4]);
    end
  end

  assign held      = held_q;
  assign valid     = valid_q;
  assign cap_pulse = cap_pulse_q;
  assign cap_count = cap_count_q;
  assign hex0      = hex0_q;
  assign hex1      = hex1_q;

endmodule

// File: tb/tb_lfsr_capture_display.sv
// tb/tb_lfsr_capture_display.sv - vector table, corner sequences and randomized run against a run-length reference model
module tb_lfsr_capture_display;

  localparam int DEB = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       btn = 1'b0;
  logic [7:0] din = 8'h00;
  logic [7:0] held;
  logic       valid, cap_pulse;
  logic [3:0] cap_count;
  logic [6:0] hex0, hex1;

  lfsr_capture_display #(.DEB_CYCLES(DEB), .DEB_W(20)) dut (
    .clk(clk), .rst(rst), .din(din), .btn(btn), .held(held), .valid(valid),
    .cap_pulse(cap_pulse), .cap_count(cap_count), .hex0(hex0), .hex1(hex1)
  );

  always #5 clk = ~clk;

  logic [6:0] seg_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                               7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  int total = 0;
  int bad   = 0;
  int pulses_dut = 0;

  // Reference: the button level the logic sees is btn two edges late; a new level is
  // accepted once it has been seen DEB times in a row, and accepting "pressed" captures.
  logic       h1, h2, m_stable, m_pulse, m_valid;
  int         m_run;
  logic [7:0] m_held;
  logic [3:0] m_count;

  always @(negedge clk) if (cap_pulse) pulses_dut++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    h1 = 0; h2 = 0; m_stable = 0; m_pulse = 0; m_valid = 0;
    m_run = 0; m_held = 8'h00; m_count = 4'h0;
  endtask

  task automatic model_edge(input logic b, input logic [7:0] d);
    logic s;
    s = h2; h2 = h1; h1 = b;
    m_pulse = 1'b0;
    if (s != m_stable) begin
      m_run++;
      if (m_run == DEB) begin
        m_stable = s;
        m_run = 0;
        if (s) begin
          m_held  = d;
          m_valid = 1'b1;
          m_count = m_count + 4'd1;
          m_pulse = 1'b1;
        end
      end
    end else begin
      m_run = 0;
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".held"},      held,      m_held);
    chk({tag, ".valid"},     valid,     m_valid);
    chk({tag, ".cap_pulse"}, cap_pulse, m_pulse);
    chk({tag, ".cap_count"}, cap_count, m_count);
    chk({tag, ".hex0"},      hex0,      m_valid ? seg_tab[m_held[3:0]] : 7'h7F);
    chk({tag, ".hex1"},      hex1,      m_valid ? seg_tab[m_held[7:4]] : 7'h7F);
  endtask

  // Called at a falling edge; leaves the bench at the next falling edge.
  task automatic cycle(input logic b, input logic [7:0] d, input string tag);
    btn = b; din = d;
    @(posedge clk);
    model_edge(b, d);
    @(negedge clk);
    check_all(tag);
  endtask

  task automatic run(input logic b, input logic [7:0] d, input int n, input string tag);
    for (int i = 0; i < n; i++) cycle(b, d, tag);
  endtask

  task automatic async_reset(input string tag);
    #2 rst = 1'b1;
    model_reset();
    #1 check_all({tag, "_async"});
    @(negedge clk);
    check_all({tag, "_hold"});
    rst = 1'b0;
  endtask

  typedef struct {
    logic [7:0] d;
    int         hi;
    logic       cap;
    logic [7:0] held;
    logic [6:0] h1;
    logic [6:0] h0;
  } vec_t;

  vec_t vt [6];

  initial begin
    int exp_cnt;
    int p0;
    logic b;
    vt[0] = '{8'hA5, 10, 1'b1, 8'hA5, 7'h08, 7'h12};
    vt[1] = '{8'h11,  3, 1'b0, 8'hA5, 7'h08, 7'h12};
    vt[2] = '{8'h3C, 10, 1'b1, 8'h3C, 7'h30, 7'h46};
    vt[3] = '{8'hF0,  4, 1'b1, 8'hF0, 7'h0E, 7'h40};
    vt[4] = '{8'h77,  3, 1'b0, 8'hF0, 7'h0E, 7'h40};
    vt[5] = '{8'h00,  6, 1'b1, 8'h00, 7'h40, 7'h40};

    model_reset();
    repeat (2) @(negedge clk);
    check_all("reset");
    rst = 1'b0;
    run(1'b0, 8'h5A, 20, "idle");
    chk("idle.pulses", pulses_dut, 0);

    exp_cnt = 0;
    for (int v = 0; v < 6; v++) begin
      p0 = pulses_dut;
      run(1'b1, vt[v].d, vt[v].hi, "vec_hi");
      run(1'b0, vt[v].d, 10, "vec_lo");
      exp_cnt += int'(vt[v].cap);
      chk($sformatf("vec%0d.held", v),   held,       vt[v].held);
      chk($sformatf("vec%0d.hex1", v),   hex1,       vt[v].h1);
      chk($sformatf("vec%0d.hex0", v),   hex0,       vt[v].h0);
      chk($sformatf("vec%0d.count", v),  cap_count,  exp_cnt);
      chk($sformatf("vec%0d.pulses", v), pulses_dut - p0, int'(vt[v].cap));
    end

    // press with a one-cycle low glitch, release, then a second press
    p0 = pulses_dut;
    run(1'b1, 8'h5A, 10, "gl_hi");
    run(1'b0, 8'h5A, 1, "gl_dip");
    run(1'b1, 8'h5A, 5, "gl_hi2");
    run(1'b0, 8'h5A, 10, "gl_rel");
    run(1'b1, 8'h3C, 10, "gl_p2");
    run(1'b0, 8'h3C, 10, "gl_rel2");
    chk("glitch.pulses", pulses_dut - p0, 2);
    chk("glitch.hex1", hex1, 7'h30);
    chk("glitch.hex0", hex0, 7'h46);

    // din ramps every cycle: the byte present on the 6th edge is kept
    for (int i = 0; i < 10; i++) cycle(1'b1, 8'h10 + 8'(i), "ramp");
    run(1'b0, 8'h00, 10, "ramp_rel");
    chk("ramp.held", held, 8'h15);

    async_reset("wrap_rst");
    p0 = pulses_dut;
    for (int k = 0; k < 17; k++) begin
      run(1'b1, 8'($urandom), 5, "wrap_hi");
      run(1'b0, 8'($urandom), 8, "wrap_lo");
    end
    chk("wrap.count", cap_count, 4'd1);
    chk("wrap.pulses", pulses_dut - p0, 17);

    // reset mid-debounce after a capture of FF, button kept high through release
    run(1'b1, 8'hFF, 8, "ff_hi");
    run(1'b0, 8'hFF, 10, "ff_lo");
    chk("ff.held", held, 8'hFF);
    run(1'b1, 8'h99, 4, "deb_press");
    async_reset("mid_deb");
    chk("mid_deb.held", held, 8'h00);
    chk("mid_deb.hex0", hex0, 7'h7F);
    p0 = pulses_dut;
    run(1'b1, 8'h42, 10, "fresh");
    run(1'b0, 8'h42, 10, "fresh_rel");
    chk("fresh.held", held, 8'h42);
    chk("fresh.pulses", pulses_dut - p0, 1);

    // randomized levels of random length with a free-running din
    b = 1'b0;
    for (int r = 0; r < 80; r++) begin
      int len;
      b = ~b;
      len = int'($urandom_range(1, 8));
      for (int i = 0; i < len; i++) cycle(b, 8'($urandom), "rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
